hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the forwarding unit in the ID stage.
- Detects hazards that forwarding cannot cover: load-use, branch operand dependencies, and multi-cycle MULT/DIV occupancy.
- Drives PC/IF_ID write enables, ID_EX bubble insertion and IF_ID flush.
- Tracks the HI/LO multiply/divide unit with a busy counter and keeps a saturating stall-cycle performance counter.

Parameters:
- MUL_LATENCY, 4, cycles the MULT/DIV unit stays busy after MulStart (legal range 1..15).
- CNT_W, 16, width of the StallCycles counter.

Ports:
- Clk  input  1  pipeline clock, rising edge.
- Rst  input  1  synchronous reset, active-high.
- Rs_Id  input  5  rs field of the instruction in ID.
- Rt_Id  input  5  rt field of the instruction in ID.
- UsesRt_Id  input  1  ID instruction reads rt as a source.
- Branch_Id  input  1  ID instruction is a conditional branch (compared in ID).
- BranchTaken_Id  input  1  ID branch comparison resolves taken.
- Jump_Id  input  1  ID instruction is J/JAL/JR.
- MulDiv_Id  input  1  ID instruction is MULT/MULTU/DIV/DIVU.
- HiLoRead_Id  input  1  ID instruction is MFHI/MFLO.
- Rd_Ex  input  5  destination register in EX.
- RegWrite_Ex  input  1  EX instruction writes the register file.
- MemRead_Ex  input  1  EX instruction is a load.
- Rd_Mem  input  5  destination register in MEM.
- MemRead_Mem  input  1  MEM instruction is a load.
- PCWrite  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register update enable.
- IF_ID_Flush  output  1  zero the IF/ID register next edge.
- ID_EX_Bubble  output  1  load a NOP into ID/EX next edge.
- MulStart  output  1  one-cycle start pulse to the MULT/DIV unit.
- MulBusy  output  1  MULT/DIV unit occupied.
- StallCycles  output  CNT_W  count of cycles with PCWrite=0.

Behaviour:
- Clock and reset: one clock, Clk. Rst is synchronous and active-high.
- Outputs are combinational from the current state and inputs, so each hazard takes effect in the same cycle it is detected.
- Reset (Rst=1 sampled at an edge):
  - State is IDLE, BusyCnt=0, StallCycles=0.
  - While Rst=1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=1, MulStart=0, MulBusy=0.
  - StallCycles does not count reset cycles.
- Matching rule: match(r) = (r != 0) && (r == Rs_Id || (UsesRt_Id && r == Rt_Id)).
- LoadUse = MemRead_Ex && match(Rd_Ex).
- BrHaz = Branch_Id && ((RegWrite_Ex && match(Rd_Ex)) || (MemRead_Mem && match(Rd_Mem))).
  - JR uses the same rule, with Branch_Id asserted by the decoder.
- MulHaz = MulBusy && (MulDiv_Id || HiLoRead_Id).
- Stall = LoadUse || BrHaz || MulHaz.
  - Stall forces PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - IF_ID_Flush=0 during a stall. The branch re-resolves once operands are ready.
- No stall:
  - PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0.
  - IF_ID_Flush = BranchTaken_Id || Jump_Id.
- Stall has priority over flush and over MulStart.
- FSM (2 states):
  - IDLE: MulBusy=0. When MulDiv_Id && !Stall: MulStart=1, go to BUSY, BusyCnt <= MUL_LATENCY-1.
  - BUSY: MulBusy=1.
    - If BusyCnt==0, go to IDLE on the next edge.
    - Otherwise BusyCnt decrements by 1 each cycle.
  - MUL_LATENCY=1 returns to IDLE after exactly one BUSY cycle.
  - Only IDLE can issue MulStart, so a back-to-back MULT stalls until IDLE, then starts the same cycle.
- StallCycles:
  - Increments on each edge where Rst=0 and PCWrite=0.
  - Saturates at 2^CNT_W-1 with no wrap.
- Simultaneous events:
  - LoadUse together with BranchTaken_Id: stall, no flush.
  - MulDiv_Id together with LoadUse: stall, no MulStart, FSM stays in IDLE.
- Rst mid-BUSY abandons the operation. The next MULT restarts the full MUL_LATENCY.

Test Plan:
- LW $5 in EX (MemRead_Ex=1, Rd_Ex=5), ID ADD with Rs_Id=5 -> one cycle of PCWrite=0, ID_EX_Bubble=1, StallCycles 0->1. Next cycle MemRead_Ex=0, so no stall.
- Rd_Ex=0 with MemRead_Ex=1 and Rs_Id=0 -> no stall. Also Rt_Id=5 with UsesRt_Id=0 and Rd_Ex=5 -> no stall.
- BEQ in ID (Branch_Id=1, BranchTaken_Id=1), RegWrite_Ex=1, Rd_Ex=Rt_Id=7 -> stall 1 cycle with IF_ID_Flush=0. Next cycle (dependency cleared): IF_ID_Flush=1, PCWrite=1.
- MUL_LATENCY=4, MULT in ID with no hazard -> MulStart=1 for one cycle, then MulBusy=1 for 4 cycles. MFHI arriving 1 cycle later stalls 3 cycles then proceeds; StallCycles rises by 3.
- MULT followed immediately by MULT -> second stalls through BUSY. MulStart reasserts in the first IDLE cycle, and exactly 2 MulStart pulses occur in total.
- Rst=1 in the 2nd BUSY cycle -> next cycle IDLE, MulBusy=0, StallCycles=0. With CNT_W=4, forcing 20 stall cycles -> StallCycles holds 15.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// ============================================================================
// Module      : hazard_stall_controller_if
// Description : Bundle between the ID-stage decode/pipeline registers and the
//               hazard stall controller. It carries the hazard inputs from the
//               ID/EX/MEM stages and returns the pipeline control outputs.
//   master : pipeline side. Drives the decode/stage fields and receives the
//            enables, bubble, flush, MULT/DIV handshake and stall counter.
//   slave  : controller side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    // ID-stage instruction fields
    logic [4:0]       Rs_Id;
    logic [4:0]       Rt_Id;
    logic             UsesRt_Id;
    logic             Branch_Id;
    logic             BranchTaken_Id;
    logic             Jump_Id;
    logic             MulDiv_Id;
    logic             HiLoRead_Id;
    // EX / MEM stage producers
    logic [4:0]       Rd_Ex;
    logic             RegWrite_Ex;
    logic             MemRead_Ex;
    logic [4:0]       Rd_Mem;
    logic             MemRead_Mem;
    // Pipeline control
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Bubble;
    logic             MulStart;
    logic             MulBusy;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output Rs_Id, Rt_Id, UsesRt_Id, Branch_Id, BranchTaken_Id, Jump_Id,
               MulDiv_Id, HiLoRead_Id, Rd_Ex, RegWrite_Ex, MemRead_Ex,
               Rd_Mem, MemRead_Mem,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulStart,
               MulBusy, StallCycles
    );

    modport slave (
        input  Rs_Id, Rt_Id, UsesRt_Id, Branch_Id, BranchTaken_Id, Jump_Id,
               MulDiv_Id, HiLoRead_Id, Rd_Ex, RegWrite_Ex, MemRead_Ex,
               Rd_Mem, MemRead_Mem,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulStart,
               MulBusy, StallCycles
    );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
// ============================================================================
// Module      : hazard_stall_controller
// Description : ID-stage hazard detection for the 5-stage MIPS pipeline.
//               Stalls on load-use, on branch operand dependencies that are
//               still in flight, and on MULT/DIV/MFHI/MFLO while the HI/LO
//               unit is busy. It also flushes IF/ID on taken branches and
//               jumps, issues the MULT/DIV start pulse, and counts stall cycles
//               in a saturating counter.
//   Clk  : pipeline clock, rising edge
//   Rst  : synchronous reset, active high
//   bus  : slave side of hazard_stall_controller_if (hazard inputs in,
//          PCWrite/IF_ID_Write/IF_ID_Flush/ID_EX_Bubble/MulStart/MulBusy/
//          StallCycles out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller #(
    parameter int MUL_LATENCY = 4,   // 1..15
    parameter int CNT_W       = 16
) (
    input  wire logic                    Clk,
    input  wire logic                    Rst,
    hazard_stall_controller_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0]       c_BUSY_INIT = 4'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q,     state_d;
    logic [3:0]       busy_cnt_q,  busy_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic w_ex_match;
    logic w_mem_match;
    logic w_load_use;
    logic w_br_haz;
    logic w_mul_haz;
    logic w_stall;
    logic w_busy;
    logic w_mul_start;
    logic w_pc_write;

    // Register 0 is hardwired to zero and never a real dependency.
    assign w_ex_match  = (bus.Rd_Ex != 5'd0) &&
                         ((bus.Rd_Ex == bus.Rs_Id) ||
                          (bus.UsesRt_Id && (bus.Rd_Ex == bus.Rt_Id)));
    assign w_mem_match = (bus.Rd_Mem != 5'd0) &&
                         ((bus.Rd_Mem == bus.Rs_Id) ||
                          (bus.UsesRt_Id && (bus.Rd_Mem == bus.Rt_Id)));

    assign w_busy      = (state_q == ST_BUSY);
    assign w_load_use  = bus.MemRead_Ex && w_ex_match;
    // Branches compare in ID, so any EX result or MEM load feeding them is
    // too late for forwarding.
    assign w_br_haz    = bus.Branch_Id &&
                         ((bus.RegWrite_Ex && w_ex_match) ||
                          (bus.MemRead_Mem && w_mem_match));
    assign w_mul_haz   = w_busy && (bus.MulDiv_Id || bus.HiLoRead_Id);
    assign w_stall     = w_load_use || w_br_haz || w_mul_haz;

    // Only IDLE may launch, so a MULT behind a busy unit waits via w_mul_haz.
    assign w_mul_start = !Rst && !w_busy && bus.MulDiv_Id && !w_stall;
    assign w_pc_write  = !Rst && !w_stall;

    // Reset holds the front end frozen with a bubble and flush pending.
    always_comb begin
        bus.PCWrite      = w_pc_write;
        bus.IF_ID_Write  = w_pc_write;
        bus.ID_EX_Bubble = Rst || w_stall;
        bus.IF_ID_Flush  = Rst || (!w_stall && (bus.BranchTaken_Id || bus.Jump_Id));
        bus.MulStart     = w_mul_start;
        bus.MulBusy      = !Rst && w_busy;
        bus.StallCycles  = stall_cnt_q;
    end

    always_comb begin
        state_d     = state_q;
        busy_cnt_d  = busy_cnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_mul_start) begin
                    state_d    = ST_BUSY;
                    busy_cnt_d = c_BUSY_INIT;
                end
            end
            ST_BUSY: begin
                if (busy_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!w_pc_write && (stall_cnt_q != c_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            busy_cnt_q  <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// ============================================================================
// Module      : tb_hazard_stall_controller
// Description : Directed self-checking bench for hazard_stall_controller.
//               Main instance uses MUL_LATENCY=4, CNT_W=4; a second instance
//               uses MUL_LATENCY=1 for the single-cycle busy boundary.
//               Output vector order: {PCWrite, IF_ID_Write, IF_ID_Flush,
//               ID_EX_Bubble, MulStart, MulBusy}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_controller;

    logic Clk = 1'b0;
    logic Rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 Clk = ~Clk;

    hazard_stall_controller_if #(.CNT_W(4))  bus  ();
    hazard_stall_controller_if #(.CNT_W(16)) bus1 ();

    hazard_stall_controller #(.MUL_LATENCY(4), .CNT_W(4)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    hazard_stall_controller #(.MUL_LATENCY(1), .CNT_W(16)) dut1 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus1.slave)
    );

    localparam logic [5:0] c_RST   = 6'b001100;
    localparam logic [5:0] c_RUN   = 6'b110000;
    localparam logic [5:0] c_FLUSH = 6'b111000;
    localparam logic [5:0] c_STALL = 6'b000100;
    localparam logic [5:0] c_START = 6'b110010;
    localparam logic [5:0] c_BUSY  = 6'b110001;
    localparam logic [5:0] c_MSTL  = 6'b000101;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {26'd0, bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush,
                bus.ID_EX_Bubble, bus.MulStart, bus.MulBusy};
    endfunction

    function automatic logic [31:0] outs1();
        return {26'd0, bus1.PCWrite, bus1.IF_ID_Write, bus1.IF_ID_Flush,
                bus1.ID_EX_Bubble, bus1.MulStart, bus1.MulBusy};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        bus.Rs_Id = 5'd0;  bus.Rt_Id = 5'd0;  bus.UsesRt_Id = 1'b0;
        bus.Branch_Id = 1'b0; bus.BranchTaken_Id = 1'b0; bus.Jump_Id = 1'b0;
        bus.MulDiv_Id = 1'b0; bus.HiLoRead_Id = 1'b0;
        bus.Rd_Ex = 5'd0; bus.RegWrite_Ex = 1'b0; bus.MemRead_Ex = 1'b0;
        bus.Rd_Mem = 5'd0; bus.MemRead_Mem = 1'b0;
    endtask

    task automatic clr1();
        bus1.Rs_Id = 5'd0;  bus1.Rt_Id = 5'd0;  bus1.UsesRt_Id = 1'b0;
        bus1.Branch_Id = 1'b0; bus1.BranchTaken_Id = 1'b0; bus1.Jump_Id = 1'b0;
        bus1.MulDiv_Id = 1'b0; bus1.HiLoRead_Id = 1'b0;
        bus1.Rd_Ex = 5'd0; bus1.RegWrite_Ex = 1'b0; bus1.MemRead_Ex = 1'b0;
        bus1.Rd_Mem = 5'd0; bus1.MemRead_Mem = 1'b0;
    endtask

    initial begin
        int pulses;
        Rst = 1'b1;
        clr();
        clr1();
        tick();
        tick();
        #2;
        chk("rst_outs", outs(), c_RST);
        chk("rst_cnt", 32'(bus.StallCycles), 32'd0);
        Rst = 1'b0;

        // Load-use: LW $5 in EX, ADD reading $5 in ID.
        bus.MemRead_Ex = 1'b1; bus.Rd_Ex = 5'd5; bus.Rs_Id = 5'd5;
        #2 chk("lu_stall", outs(), c_STALL);
        tick();
        chk("lu_cnt", 32'(bus.StallCycles), 32'd1);
        bus.MemRead_Ex = 1'b0; bus.RegWrite_Ex = 1'b1;
        #2 chk("lu_release", outs(), c_RUN);
        tick();
        chk("lu_cnt_hold", 32'(bus.StallCycles), 32'd1);

        // $0 never matches; rt ignored unless used.
        clr();
        bus.MemRead_Ex = 1'b1;
        #2 chk("r0_nostall", outs(), c_RUN);
        bus.Rs_Id = 5'd1; bus.Rt_Id = 5'd5; bus.Rd_Ex = 5'd5;
        #1 chk("rt_unused", outs(), c_RUN);
        bus.UsesRt_Id = 1'b1;
        #1 chk("rt_used", outs(), c_STALL);
        tick();
        chk("rt_cnt", 32'(bus.StallCycles), 32'd2);

        // Taken BEQ depending on an EX ALU result: stall, no flush.
        clr();
        bus.Branch_Id = 1'b1; bus.BranchTaken_Id = 1'b1;
        bus.RegWrite_Ex = 1'b1; bus.Rd_Ex = 5'd7; bus.Rt_Id = 5'd7; bus.UsesRt_Id = 1'b1;
        #2 chk("br_stall", outs(), c_STALL);
        tick();
        bus.RegWrite_Ex = 1'b0;
        #2 chk("br_flush", outs(), c_FLUSH);
        tick();
        // Branch behind a MEM-stage load.
        clr();
        bus.Branch_Id = 1'b1; bus.Rs_Id = 5'd9; bus.Rd_Mem = 5'd9; bus.MemRead_Mem = 1'b1;
        #2 chk("br_mem_stall", outs(), c_STALL);
        tick();
        chk("br_cnt", 32'(bus.StallCycles), 32'd4);
        // Load-use with a taken branch: stall wins over flush.
        clr();
        bus.BranchTaken_Id = 1'b1; bus.MemRead_Ex = 1'b1; bus.Rd_Ex = 5'd3; bus.Rs_Id = 5'd3;
        #2 chk("lu_taken", outs(), c_STALL);
        tick();
        clr();
        bus.Jump_Id = 1'b1;
        #2 chk("jump_flush", outs(), c_FLUSH);
        tick();
        chk("cnt_5", 32'(bus.StallCycles), 32'd5);

        // MULT, one independent instr, then MFHI: 3 stall cycles.
        clr();
        bus.MulDiv_Id = 1'b1;
        #2 chk("mul_start", outs(), c_START);
        tick();
        clr();
        #2 chk("mul_busy1", outs(), c_BUSY);
        tick();
        bus.HiLoRead_Id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2 chk("mfhi_stall", outs(), c_MSTL);
            tick();
        end
        #2 chk("mfhi_go", outs(), c_RUN);
        chk("mfhi_cnt", 32'(bus.StallCycles), 32'd8);
        tick();

        // Back-to-back MULT: second waits through all 4 busy cycles.
        clr();
        bus.MulDiv_Id = 1'b1;
        pulses = 0;
        #2 chk("mm_start1", outs(), c_START);
        pulses += int'(bus.MulStart);
        tick();
        for (int i = 0; i < 4; i++) begin
            #2 chk("mm_wait", outs(), c_MSTL);
            pulses += int'(bus.MulStart);
            tick();
        end
        #2 chk("mm_start2", outs(), c_START);
        pulses += int'(bus.MulStart);
        tick();
        clr();
        chk("mm_pulses", 32'(pulses), 32'd2);
        chk("mm_cnt", 32'(bus.StallCycles), 32'd12);

        // Reset in the 2nd BUSY cycle abandons the operation.
        tick();
        for (int i = 0; i < 3; i++) tick();
        tick();
        bus.MulDiv_Id = 1'b1;
        tick();
        clr();
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        #2 chk("rst_busy_outs", outs(), c_RUN);
        chk("rst_busy_cnt", 32'(bus.StallCycles), 32'd0);
        bus.MulDiv_Id = 1'b1;
        #1 chk("restart", outs(), c_START);
        tick();
        clr();
        for (int i = 0; i < 4; i++) begin
            #2 chk("restart_busy", outs(), c_BUSY);
            tick();
        end
        #2 chk("restart_idle", outs(), c_RUN);

        // MULT with load-use: stall, no start, FSM stays IDLE.
        bus.MulDiv_Id = 1'b1; bus.MemRead_Ex = 1'b1; bus.Rd_Ex = 5'd4; bus.Rs_Id = 5'd4;
        #1 chk("mul_lu", outs(), c_STALL);
        tick();
        clr();
        #2 chk("mul_lu_idle", outs(), c_RUN);

        // Saturation at 15 with CNT_W=4.
        bus.MemRead_Ex = 1'b1; bus.Rd_Ex = 5'd5; bus.Rs_Id = 5'd5;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt", 32'(bus.StallCycles), 32'd15);
        clr();

        // MUL_LATENCY=1: exactly one BUSY cycle.
        bus1.MulDiv_Id = 1'b1;
        #2 chk("ml1_start", outs1(), c_START);
        tick();
        #2 chk("ml1_busy", outs1(), c_MSTL);
        tick();
        #2 chk("ml1_restart", outs1(), c_START);
        tick();
        clr1();
        chk("ml1_cnt", 32'(bus1.StallCycles), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
